// File: rtl/formation_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : formation_ctrl
// Brief    : Enemy formation sequencer: march/descend timing, wave clearing
//            and round-robin enemy shot arbitration across three rows.
// Revision : 1.0
// ============================================================================
module formation_ctrl #(
    parameter int Y_START       = 40,
    parameter int ROW_PITCH     = 40,
    parameter int Y_STEP        = 4,
    parameter int Y_MAX         = 360,
    parameter int FIRE_INTERVAL = 16,
    parameter int CLEAR_TICKS   = 60
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        play,
    input  logic        done,
    input  logic [17:0] alive_mask,
    input  logic [2:0]  fire_req,
    output logic [9:0]  y_offset0,
    output logic [9:0]  y_offset1,
    output logic [9:0]  y_offset2,
    output logic [2:0]  shot_grant,
    output logic [3:0]  wave,
    output logic        wave_clear,
    output logic [1:0]  state
);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_MARCH      = 2'd1;
    localparam logic [1:0] c_DESCEND    = 2'd2;
    localparam logic [1:0] c_WAVE_CLEAR = 2'd3;

    localparam int               c_CLR_W     = $clog2(CLEAR_TICKS + 1);
    localparam logic [9:0]       c_Y_START   = 10'(Y_START);
    localparam logic [10:0]      c_Y_MAX     = 11'(Y_MAX);
    localparam logic [10:0]      c_Y_STEP    = 11'(Y_STEP);
    localparam logic [9:0]       c_PITCH1    = 10'(ROW_PITCH);
    localparam logic [9:0]       c_PITCH2    = 10'(2 * ROW_PITCH);
    localparam logic [3:0]       c_FIRE_LAST = 4'(FIRE_INTERVAL - 1);
    localparam logic [c_CLR_W-1:0] c_CLR_LAST = c_CLR_W'(CLEAR_TICKS - 1);

    logic               r_fc_s1;
    logic               r_fc_s2;
    logic [1:0]         r_state;
    logic [9:0]         r_y_base;
    logic [3:0]         r_wave;
    logic [5:0]         r_step;
    logic [3:0]         r_fire;
    logic [c_CLR_W-1:0] r_clr;
    logic [1:0]         r_ptr;
    logic               r_wave_clear;

    logic               w_tick;
    logic               w_all_dead;
    logic [5:0]         w_period;
    logic               w_step_last;
    logic               w_slot;
    logic [10:0]        w_y_sum;
    logic [9:0]         w_y_desc;
    logic [2:0]         w_elig;
    logic [1:0]         w_cand [3];
    logic [2:0]         w_grant;
    logic [1:0]         w_ptr_nxt;
    logic               w_found;

    assign w_tick      = r_fc_s1 & ~r_fc_s2;
    assign w_all_dead  = (alive_mask == 18'd0);
    // March period shrinks by two per wave and bottoms out at eight ticks.
    assign w_period    = (r_wave > 4'd12) ? 6'd8 : (6'd32 - {1'b0, r_wave, 1'b0});
    assign w_step_last = (r_step == (w_period - 6'd1));
    assign w_slot      = (r_state == c_MARCH) && play && !done && w_tick
                         && !w_all_dead && (r_fire == c_FIRE_LAST);
    assign w_y_sum     = {1'b0, r_y_base} + c_Y_STEP;
    assign w_y_desc    = (w_y_sum > c_Y_MAX) ? c_Y_MAX[9:0] : w_y_sum[9:0];

    for (genvar r = 0; r < 3; r++) begin : g_elig
        assign w_elig[r] = fire_req[r] & (|alive_mask[6*r +: 6]);
    end

    always_comb begin
        case (r_ptr)
            2'd1:    w_cand = '{2'd1, 2'd2, 2'd0};
            2'd2:    w_cand = '{2'd2, 2'd0, 2'd1};
            default: w_cand = '{2'd0, 2'd1, 2'd2};
        endcase
    end

    always_comb begin
        w_grant   = 3'b000;
        w_ptr_nxt = r_ptr;
        w_found   = 1'b0;
        if (w_slot) begin
            for (int k = 0; k < 3; k++) begin
                if (!w_found && w_elig[w_cand[k]]) begin
                    w_found             = 1'b1;
                    w_grant[w_cand[k]]  = 1'b1;
                    w_ptr_nxt           = (w_cand[k] == 2'd2) ? 2'd0 : (w_cand[k] + 2'd1);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_fc_s1      <= 1'b0;
            r_fc_s2      <= 1'b0;
            r_state      <= c_IDLE;
            r_y_base     <= c_Y_START;
            r_wave       <= 4'd0;
            r_step       <= 6'd0;
            r_fire       <= 4'd0;
            r_clr        <= '0;
            r_ptr        <= 2'd0;
            r_wave_clear <= 1'b0;
        end else begin
            r_fc_s1      <= frame_clk;
            r_fc_s2      <= r_fc_s1;
            r_wave_clear <= 1'b0;
            if (done) begin
                r_state  <= c_IDLE;
                r_y_base <= c_Y_START;
                r_wave   <= 4'd0;
                r_step   <= 6'd0;
                r_fire   <= 4'd0;
                r_clr    <= '0;
                r_ptr    <= 2'd0;
            end else if (play) begin
                case (r_state)
                    c_IDLE: r_state <= c_MARCH;
                    c_MARCH: begin
                        if (w_all_dead) begin
                            r_state      <= c_WAVE_CLEAR;
                            r_wave_clear <= 1'b1;
                            r_clr        <= '0;
                        end else if (w_tick) begin
                            r_fire <= (r_fire == c_FIRE_LAST) ? 4'd0 : (r_fire + 4'd1);
                            r_ptr  <= w_ptr_nxt;
                            if (w_step_last) begin
                                r_step  <= 6'd0;
                                r_state <= c_DESCEND;
                            end else begin
                                r_step <= r_step + 6'd1;
                            end
                        end
                    end
                    c_DESCEND: begin
                        if (w_all_dead) begin
                            r_state      <= c_WAVE_CLEAR;
                            r_wave_clear <= 1'b1;
                            r_clr        <= '0;
                        end else begin
                            r_y_base <= w_y_desc;
                            r_state  <= c_MARCH;
                        end
                    end
                    c_WAVE_CLEAR: begin
                        if (w_tick) begin
                            if (r_clr == c_CLR_LAST) begin
                                r_clr    <= '0;
                                r_wave   <= (r_wave == 4'd15) ? 4'd15 : (r_wave + 4'd1);
                                r_y_base <= c_Y_START;
                                r_step   <= 6'd0;
                                r_state  <= c_MARCH;
                            end else begin
                                r_clr <= r_clr + 1'b1;
                            end
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

    assign y_offset0  = r_y_base;
    assign y_offset1  = r_y_base + c_PITCH1;
    assign y_offset2  = r_y_base + c_PITCH2;
    assign shot_grant = w_grant;
    assign wave       = r_wave;
    assign wave_clear = r_wave_clear;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_formation_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_formation_ctrl
// Brief    : Self-checking bench for formation_ctrl against a tick-level model.
// Revision : 1.0
// ============================================================================
module tb_formation_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic        play;
    logic        done;
    logic [17:0] alive_mask;
    logic [2:0]  fire_req;
    logic [9:0]  y_offset0, y_offset1, y_offset2;
    logic [2:0]  shot_grant;
    logic [3:0]  wave;
    logic        wave_clear;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    // Tick-level model: mode 0 idle, 1 marching, 3 clearing.
    int m_mode, m_y, m_wave, m_step, m_fire, m_clr, m_ptr;
    logic [2:0] m_grant;

    logic [2:0] obs_grant;
    int obs_gcyc, obs_wc;
    int obs_bad = 0;
    logic [2:0] gseq [$];

    formation_ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .play       (play),
        .done       (done),
        .alive_mask (alive_mask),
        .fire_req   (fire_req),
        .y_offset0  (y_offset0),
        .y_offset1  (y_offset1),
        .y_offset2  (y_offset2),
        .shot_grant (shot_grant),
        .wave       (wave),
        .wave_clear (wave_clear),
        .state      (state)
    );

    always #10 Clk = ~Clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int period_of(input int w);
        return (32 - 2 * w < 8) ? 8 : 32 - 2 * w;
    endfunction

    function automatic void m_reset();
        m_mode = 0; m_y = 40; m_wave = 0; m_step = 0;
        m_fire = 0; m_clr = 0; m_ptr = 0; m_grant = 3'b000;
    endfunction

    function automatic void model_tick();
        m_grant = 3'b000;
        if (!play || m_mode == 0) return;
        if (m_mode == 1) begin
            m_fire = (m_fire + 1) % 16;
            if (m_fire == 0) begin
                for (int k = 0; k < 3; k++) begin
                    int r = (m_ptr + k) % 3;
                    if (m_grant == 3'b000 && fire_req[r] && alive_mask[6*r +: 6] != 6'd0) begin
                        m_grant = 3'(1 << r);
                        m_ptr   = (r + 1) % 3;
                    end
                end
            end
            m_step++;
            if (m_step == period_of(m_wave)) begin
                m_step = 0;
                m_y = (m_y + 4 > 360) ? 360 : m_y + 4;
            end
        end else begin
            m_clr++;
            if (m_clr == 60) begin
                m_clr = 0; m_wave = (m_wave == 15) ? 15 : m_wave + 1;
                m_y = 40; m_step = 0; m_mode = 1;
            end
        end
    endfunction

    task automatic sample_cycle();
        @(posedge Clk); #1;
        if (shot_grant != 3'b000) begin
            obs_gcyc++;
            obs_grant |= shot_grant;
            if (state != 2'd1 || !$onehot(shot_grant)) obs_bad++;
        end
        if (wave_clear) obs_wc++;
    endtask

    task automatic do_tick(input int hi = 4, input int lo = 3);
        obs_grant = 3'b000; obs_gcyc = 0; obs_wc = 0;
        frame_clk = 1'b1;
        repeat (hi) sample_cycle();
        frame_clk = 1'b0;
        repeat (lo) sample_cycle();
        model_tick();
    endtask

    task automatic set_alive(input logic [17:0] v);
        alive_mask = v;
        obs_grant = 3'b000; obs_gcyc = 0; obs_wc = 0;
        repeat (3) sample_cycle();
        if (play && m_mode == 1 && v == 18'd0) begin
            m_mode = 3; m_clr = 0;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0; frame_clk = 1'b0; play = 1'b0; done = 1'b0;
        alive_mask = '1; fire_req = 3'b000;
        repeat (3) @(posedge Clk); #1;
        m_reset();
        checks++;
        if (y_offset0 !== 10'd40 || y_offset1 !== 10'd80 || y_offset2 !== 10'd120) begin
            errors++;
            $display("FAIL reset_y: got %0d/%0d/%0d want 40/80/120", y_offset0, y_offset1, y_offset2);
        end
        checks++;
        if (state !== 2'd0 || wave !== 4'd0 || shot_grant !== 3'b000 || wave_clear !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: state %0d wave %0d grant %b wc %b want 0 0 000 0",
                     state, wave, shot_grant, wave_clear);
        end
        Reset = 1'b1;
        repeat (3) @(posedge Clk); #1;
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL idle_hold: state %0d want 0", state);
        end
    endtask

    task automatic test_first_descend();
        play = 1'b1;
        @(posedge Clk); #1;
        m_mode = 1;
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL enter_march: state %0d want 1", state);
        end
        for (int t = 1; t <= 32; t++) begin
            do_tick();
            checks++;
            if (y_offset0 !== 10'(m_y) || obs_gcyc != 0) begin
                errors++;
                $display("FAIL march_tick%0d: y0 %0d grants %0d want y0 %0d grants 0", t, y_offset0, obs_gcyc, m_y);
            end
        end
        checks++;
        if (y_offset0 !== 10'd44 || y_offset2 !== 10'd124) begin
            errors++;
            $display("FAIL first_descend: y0 %0d y2 %0d want 44 124", y_offset0, y_offset2);
        end
    endtask

    task automatic test_saturate();
        for (int t = 0; t < 99 * 32; t++) begin
            fire_req = 3'($urandom);
            do_tick();
            checks++;
            if (y_offset0 !== 10'(m_y) || obs_grant !== m_grant || obs_gcyc != int'(m_grant != 3'b000)) begin
                errors++;
                $display("FAIL saturate_tick%0d: y0 %0d grant %b x%0d want y0 %0d grant %b",
                         t, y_offset0, obs_grant, obs_gcyc, m_y, m_grant);
            end
        end
        checks++;
        if (y_offset0 !== 10'd360 || y_offset2 !== 10'd440) begin
            errors++;
            $display("FAIL saturate: y0 %0d y2 %0d want 360 440", y_offset0, y_offset2);
        end
    endtask

    task automatic test_wave_clear();
        fire_req = 3'b000;
        repeat (5) do_tick();
        set_alive(18'd0);
        checks++;
        if (obs_wc != 1 || state !== 2'd3) begin
            errors++;
            $display("FAIL wave_clear_pulse: pulses %0d state %0d want 1 3", obs_wc, state);
        end
        set_alive('1);
        for (int t = 1; t <= 60; t++) begin
            do_tick();
            checks++;
            if (state !== 2'(m_mode) || wave !== 4'(m_wave) || y_offset0 !== 10'(m_y)) begin
                errors++;
                $display("FAIL clear_tick%0d: state %0d wave %0d y0 %0d want %0d %0d %0d",
                         t, state, wave, y_offset0, m_mode, m_wave, m_y);
            end
        end
        checks++;
        if (wave !== 4'd1 || y_offset0 !== 10'd40 || state !== 2'd1) begin
            errors++;
            $display("FAIL clear_done: wave %0d y0 %0d state %0d want 1 40 1", wave, y_offset0, state);
        end
        for (int t = 1; t <= 30; t++) begin
            do_tick();
            if (t == 29) begin
                checks++;
                if (y_offset0 !== 10'd40) begin
                    errors++;
                    $display("FAIL wave1_early: y0 %0d want 40", y_offset0);
                end
            end
        end
        checks++;
        if (y_offset0 !== 10'd44) begin
            errors++;
            $display("FAIL wave1_descend: y0 %0d want 44", y_offset0);
        end
    endtask

    task automatic test_grants();
        logic [2:0] exp_a [4];
        logic [2:0] exp_b [3];
        exp_a = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_b = '{3'b100, 3'b001, 3'b100};
        done = 1'b1;
        @(posedge Clk); #1;
        done = 1'b0;
        m_reset();
        @(posedge Clk); #1;
        m_mode = 1;
        alive_mask = '1; fire_req = 3'b111;
        gseq.delete();
        for (int t = 0; t < 64; t++) begin
            do_tick();
            checks++;
            if (obs_grant !== m_grant || obs_gcyc != int'(m_grant != 3'b000)) begin
                errors++;
                $display("FAIL rr_tick%0d: grant %b x%0d want %b", t, obs_grant, obs_gcyc, m_grant);
            end
            if (obs_grant != 3'b000) gseq.push_back(obs_grant);
        end
        checks++;
        if (gseq.size() != 4 || gseq[0] !== exp_a[0] || gseq[1] !== exp_a[1]
            || gseq[2] !== exp_a[2] || gseq[3] !== exp_a[3]) begin
            errors++;
            $display("FAIL rr_all_alive: got %0d grants %p want 001 010 100 001", gseq.size(), gseq);
        end
        alive_mask = 18'h3F03F;
        gseq.delete();
        for (int t = 0; t < 48; t++) begin
            do_tick();
            checks++;
            if (obs_grant !== m_grant) begin
                errors++;
                $display("FAIL rr_skip_tick%0d: grant %b want %b", t, obs_grant, m_grant);
            end
            if (obs_grant != 3'b000) gseq.push_back(obs_grant);
        end
        checks++;
        if (gseq.size() != 3 || gseq[0] !== exp_b[0] || gseq[1] !== exp_b[1] || gseq[2] !== exp_b[2]) begin
            errors++;
            $display("FAIL rr_row1_dead: got %0d grants %p want 100 001 100", gseq.size(), gseq);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 300; t++) begin
            logic [17:0] a;
            a = 18'($urandom);
            if (a == 18'd0) a = 18'd1;
            alive_mask = a;
            fire_req   = 3'($urandom);
            play       = ($urandom_range(0, 9) != 0);
            do_tick($urandom_range(4, 6), $urandom_range(3, 5));
            checks++;
            if (y_offset0 !== 10'(m_y) || y_offset1 !== 10'(m_y + 40) || y_offset2 !== 10'(m_y + 80)
                || wave !== 4'(m_wave) || state !== 2'(m_mode) || obs_grant !== m_grant
                || obs_gcyc != int'(m_grant != 3'b000)) begin
                errors++;
                $display("FAIL random_tick%0d: y %0d/%0d/%0d wave %0d state %0d grant %b want y0 %0d wave %0d state %0d grant %b",
                         t, y_offset0, y_offset1, y_offset2, wave, state, obs_grant, m_y, m_wave, m_mode, m_grant);
            end
        end
        play = 1'b1;
    endtask

    task automatic test_freeze();
        int y_hold;
        alive_mask = '1; fire_req = 3'b111; play = 1'b0;
        y_hold = m_y;
        for (int t = 0; t < 100; t++) begin
            do_tick();
            checks++;
            if (y_offset0 !== 10'(m_y) || obs_gcyc != 0 || state !== 2'd1) begin
                errors++;
                $display("FAIL freeze_tick%0d: y0 %0d grants %0d state %0d want %0d 0 1",
                         t, y_offset0, obs_gcyc, state, m_y);
            end
        end
        checks++;
        if (y_offset0 !== 10'(y_hold)) begin
            errors++;
            $display("FAIL freeze_y: y0 %0d want %0d", y_offset0, y_hold);
        end
        play = 1'b1;
    endtask

    task automatic test_done_in_clear();
        set_alive(18'd0);
        checks++;
        if (obs_wc != 1) begin
            errors++;
            $display("FAIL clear2_pulse: pulses %0d want 1", obs_wc);
        end
        set_alive('1);
        repeat (60) do_tick();
        checks++;
        if (wave !== 4'(m_wave) || m_wave == 0) begin
            errors++;
            $display("FAIL clear2_wave: wave %0d want %0d", wave, m_wave);
        end
        set_alive(18'd0);
        repeat (5) do_tick();
        done = 1'b1;
        @(posedge Clk); #1;
        checks++;
        if (state !== 2'd0 || wave !== 4'd0 || y_offset0 !== 10'd40 || shot_grant !== 3'b000) begin
            errors++;
            $display("FAIL done_override: state %0d wave %0d y0 %0d grant %b want 0 0 40 000",
                     state, wave, y_offset0, shot_grant);
        end
        done = 1'b0;
        alive_mask = '1;
        m_reset();
        @(posedge Clk); #1;
        m_mode = 1;
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL restart_march: state %0d want 1", state);
        end
    endtask

    task automatic test_reset_mid_descend();
        int guard = 0;
        bit found = 0;
        while (m_step != period_of(m_wave) - 1 && guard < 100) begin
            do_tick();
            guard++;
        end
        frame_clk = 1'b1;
        for (int i = 0; i < 6 && !found; i++) begin
            @(posedge Clk); #1;
            if (state == 2'd2) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_descend: state %0d want 2 within 6 cycles", state);
        end else begin
            #3 Reset = 1'b0;
            #1;
            checks++;
            if (y_offset0 !== 10'd40 || y_offset1 !== 10'd80 || y_offset2 !== 10'd120
                || state !== 2'd0 || shot_grant !== 3'b000 || wave_clear !== 1'b0 || wave !== 4'd0) begin
                errors++;
                $display("FAIL async_reset: y %0d/%0d/%0d state %0d grant %b wc %b wave %0d want 40/80/120 0 000 0 0",
                         y_offset0, y_offset1, y_offset2, state, shot_grant, wave_clear, wave);
            end
        end
        frame_clk = 1'b0;
        repeat (2) @(posedge Clk); #1;
        Reset = 1'b1;
        m_reset();
        @(posedge Clk); #1;
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL post_reset_march: state %0d want 1", state);
        end
    endtask

    initial begin
        test_reset();
        test_first_descend();
        test_saturate();
        test_wave_clear();
        test_grants();
        test_random();
        test_freeze();
        test_done_in_clear();
        test_reset_mid_descend();
        checks++;
        if (obs_bad != 0) begin
            errors++;
            $display("FAIL grant_shape: %0d cycles with grant outside MARCH or not one-hot, want 0", obs_bad);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/formation_ctrl.md
FORMATION_CTRL -- requirements
Module: formation_ctrl

Interface
REQ-001 The parameters SHALL be (name, default, meaning):
- Y_START, 40, initial y_base in pixels
- ROW_PITCH, 40, vertical spacing between rows in pixels
- Y_STEP, 4, pixels added to y_base per descend
- Y_MAX, 360, saturation limit for y_base
- FIRE_INTERVAL, 16, frame ticks between shot slots
- CLEAR_TICKS, 60, frame ticks spent in WAVE_CLEAR
REQ-002 The ports SHALL be (name, direction, width, meaning):
- Clk, in, 1, 50 MHz clock
- Reset, in, 1, asynchronous active-low reset
- frame_clk, in, 1, ~60 Hz frame clock, sampled in Clk domain
- play, in, 1, high when the game is in play state
- done, in, 1, game finished; restart the formation
- alive_mask, in, 18, ship-alive bits; row r occupies bits [6r+5:6r]
- fire_req, in, 3, per-row request to fire an enemy shot
- y_offset0 / y_offset1 / y_offset2, out, 10 each, per-row y position fed to each row's y_offset input
- shot_grant, out, 3, one-hot, one-Clk pulse granting a row's shot
- wave, out, 4, current wave number
- wave_clear, out, 1, one-Clk pulse on entering WAVE_CLEAR
- state, out, 2, FSM state encoding

Function
REQ-003 Clock and reset SHALL be one clock, Clk; Reset is asynchronous, active-low.
REQ-004 Tick generation SHALL register frame_clk twice in Clk; tick = one-Clk pulse on a sampled rising edge.
REQ-005 The FSM states SHALL be IDLE=0, MARCH=1, DESCEND=2, WAVE_CLEAR=3.
REQ-006 IDLE SHALL go to MARCH on the first Clk with play=1 and done=0.
REQ-007 In MARCH, a 6-bit step counter SHALL increment per tick while play=1.
- Period = max(32 - 2*wave, 8).
- When counter = period-1 on a tick, the counter clears and the FSM enters DESCEND.
REQ-008 DESCEND SHALL last exactly one Clk.
- y_base <= min(y_base + Y_STEP, Y_MAX).
- The FSM then returns to MARCH.
REQ-009 Outputs SHALL be y_offset_r = y_base + r*ROW_PITCH, 10-bit, with no wrap; parameters guarantee Y_MAX + 2*ROW_PITCH < 1024.
REQ-010 When alive_mask == 0 while in MARCH or DESCEND, the FSM SHALL enter WAVE_CLEAR on the next Clk, pulse wave_clear for 1 Clk, and clear the clear counter.
- This takes priority over a tick-driven DESCEND.
REQ-011 WAVE_CLEAR SHALL hold y_base and count CLEAR_TICKS ticks, then:
- wave <= min(wave+1, 15)
- y_base <= Y_START
- step counter <= 0
- FSM returns to MARCH
REQ-012 With play=0 the block SHALL freeze: no counter advance, no state change except on done, no shot grants.
REQ-013 Shot slots: a 4-bit fire counter SHALL increment per tick in MARCH while play=1; the slot opens when it wraps from FIRE_INTERVAL-1 to 0.
REQ-014 Eligibility: row r SHALL be eligible in an open slot iff fire_req[r]=1 and its 6 alive bits are nonzero.
REQ-015 Arbitration SHALL be round-robin with a 2-bit pointer (values 0..2).
- Search order: pointer, pointer+1, pointer+2 (mod 3).
- The first eligible row gets shot_grant bit high for exactly 1 Clk.
- Pointer <= granted row + 1 (mod 3).
- No eligible row: no grant, pointer unchanged.
REQ-016 shot_grant SHALL be 0 outside MARCH and at most one bit SHALL ever be set.
REQ-017 done=1 SHALL override everything in the same Clk: FSM -> IDLE; y_base=Y_START; wave=0; all counters and pointer=0; no grant.
REQ-018 Simultaneous events SHALL resolve as: done > wave clear > descend > shot grant. A shot grant and a descend trigger in the same tick are both taken.

Reset
REQ-019 While Reset=0 all state SHALL clear asynchronously:
- state=IDLE, y_base=Y_START, y_offset0/1/2 = 40/80/120
- wave=0, shot_grant=0, wave_clear=0
- counters, pointer and the frame_clk sync registers = 0
REQ-020 After Reset deasserts, the block SHALL resume normal function on the first Clk edge.
REQ-021 Reset asserted mid-operation SHALL abandon any state immediately, with no pending pulse.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Reset, then play=1, all alive, wave=0; 32 ticks -> one DESCEND; y_offset0=44, y_offset2=124.
- Continue for 100 descends -> y_offset0 saturates at 360, y_offset2=440.
- alive_mask->0 mid-MARCH -> wave_clear pulse; after 60 ticks wave=1, y_offset0=40; next descend after 30 ticks.
- fire_req=3'b111, all alive, 4 slots -> grants 001, 010, 100, 001. Row1 dead -> sequence skips row1.
- play=0 for 100 ticks -> no y change, no grant. done pulse during WAVE_CLEAR -> IDLE, wave=0, y_offset0=40.
- Reset asserted mid-DESCEND -> outputs at reset values asynchronously, shot_grant=0.
